// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle control sequencer.
//   - Sequencer state encoding (plain constants so older tools and
//     dumps that expect raw codes keep working).
//   - PC update select and write-back select encodings.
//   - Packed decoder control bundle as latched by the sequencer.
package ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_EXEC   = 3'd1;
    localparam state_t ST_MEM_RD = 3'd2;
    localparam state_t ST_MEM_WR = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    localparam logic [1:0] PC_SEL_SEQ = 2'd0;
    localparam logic [1:0] PC_SEL_BR  = 2'd1;
    localparam logic [1:0] PC_SEL_JMP = 2'd2;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_MEM = 1'b1;

    typedef struct packed {
        logic regdest;
        logic alusrc;
        logic memtoreg;
        logic regwrite;
        logic memread;
        logic memwrite;
        logic branch;
        logic ext;
        logic jump;
        logic jspa;
        logic aluop1;
        logic aluop2;
    } ctl_bundle_t;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on a memory acknowledge.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : clear the count (no request outstanding)
//   en_i        : a request is outstanding and not acknowledged this cycle
//   expired_o   : this is the MEM_TIMEOUT-th unacknowledged wait cycle
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count starts at 0 in the first wait cycle, so the last allowed cycle sees MEM_TIMEOUT-1.
    assign expired_o = en_i && (cnt_q == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/ctrl_exec_sequencer.sv
// ctrl_exec_sequencer: executes one decoded control bundle over several cycles.
//   clk, rst_n            : clock, asynchronous active-low reset
//   ctl_valid_i/ready_o   : bundle handshake (ready only in IDLE)
//   regdest_i..aluop2_i   : decoder control bundle
//   br_cond_i             : branch condition, sampled in EXEC
//   mem_req_o/we_o/ack_i  : data-memory handshake
//   rf_we_o, wb_sel_o     : register-file write strobe and source select
//   rf_dst_rd_o           : latched regdest
//   pc_we_o, pc_sel_o     : PC update strobe and source select
//   retire_o, retired_cnt_o : completion pulse and running count
//   mem_err_o             : sticky memory timeout flag
module ctrl_exec_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RETIRE_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ctl_valid_i,
    output logic                ctl_ready_o,
    input  logic                regdest_i,
    input  logic                alusrc_i,
    input  logic                memtoreg_i,
    input  logic                regwrite_i,
    input  logic                memread_i,
    input  logic                memwrite_i,
    input  logic                branch_i,
    input  logic                ext_i,
    input  logic                jump_i,
    input  logic                jspa_i,
    input  logic                aluop1_i,
    input  logic                aluop2_i,
    input  logic                br_cond_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    input  logic                mem_ack_i,
    output logic                rf_we_o,
    output logic                wb_sel_o,
    output logic                rf_dst_rd_o,
    output logic                pc_we_o,
    output logic [1:0]          pc_sel_o,
    output logic                retire_o,
    output logic [RETIRE_W-1:0] retired_cnt_o,
    output logic                mem_err_o
);

    state_t              state_q, state_d;
    ctl_bundle_t         bundle_q, bundle_d, bundle_in;
    logic                br_taken_q, br_taken_d;
    logic                gap_q, gap_d;
    logic                mem_err_q, mem_err_d;
    logic [RETIRE_W-1:0] retired_cnt_q, retired_cnt_d;
    logic                tmr_expired;

    assign bundle_in = '{regdest: regdest_i, alusrc: alusrc_i, memtoreg: memtoreg_i,
                         regwrite: regwrite_i, memread: memread_i, memwrite: memwrite_i,
                         branch: branch_i, ext: ext_i, jump: jump_i, jspa: jspa_i,
                         aluop1: aluop1_i, aluop2: aluop2_i};

    // Datapath-only fields travel with the bundle but do not steer sequencing.
    logic unused_bundle;
    assign unused_bundle = ^{bundle_q.alusrc, bundle_q.ext, bundle_q.jspa,
                             bundle_q.aluop1, bundle_q.aluop2};

    // gap_q marks the first MEM_WR cycle after a read so jspa's two requests are separated.
    assign ctl_ready_o = (state_q == ST_IDLE);
    assign mem_req_o   = (state_q == ST_MEM_RD) || ((state_q == ST_MEM_WR) && !gap_q);
    assign mem_we_o    = (state_q == ST_MEM_WR) && !gap_q;
    assign rf_we_o     = (state_q == ST_WB);
    assign wb_sel_o    = (state_q == ST_WB) ? bundle_q.memtoreg : WB_ALU;
    assign rf_dst_rd_o = bundle_q.regdest;
    assign pc_we_o     = (state_q == ST_DONE);
    assign retire_o    = (state_q == ST_DONE);
    assign mem_err_o   = mem_err_q;
    assign retired_cnt_o = retired_cnt_q;

    always_comb begin
        pc_sel_o = PC_SEL_SEQ;
        if (state_q == ST_DONE) begin
            if (bundle_q.jump) begin
                pc_sel_o = PC_SEL_JMP;
            end else if (br_taken_q) begin
                pc_sel_o = PC_SEL_BR;
            end
        end
    end

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!mem_req_o),
        .en_i      (mem_req_o && !mem_ack_i),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d       = state_q;
        bundle_d      = bundle_q;
        br_taken_d    = br_taken_q;
        gap_d         = gap_q;
        mem_err_d     = mem_err_q;
        retired_cnt_d = retired_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ctl_valid_i) begin
                    bundle_d   = bundle_in;
                    br_taken_d = 1'b0;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                br_taken_d = bundle_q.branch & br_cond_i;
                // memwrite is checked before regwrite, so store+regwrite stays store-only.
                if (bundle_q.memread) begin
                    state_d = ST_MEM_RD;
                end else if (bundle_q.memwrite) begin
                    state_d = ST_MEM_WR;
                end else if (bundle_q.regwrite) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_MEM_RD: begin
                if (mem_ack_i) begin
                    if (bundle_q.memwrite) begin
                        state_d = ST_MEM_WR;
                        gap_d   = 1'b1;
                    end else if (bundle_q.regwrite) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (tmr_expired) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_MEM_WR: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (mem_ack_i) begin
                    state_d = ST_DONE;
                end else if (tmr_expired) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WB: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                retired_cnt_d = retired_cnt_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bundle_q      <= '0;
            br_taken_q    <= 1'b0;
            gap_q         <= 1'b0;
            mem_err_q     <= 1'b0;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            bundle_q      <= bundle_d;
            br_taken_q    <= br_taken_d;
            gap_q         <= gap_d;
            mem_err_q     <= mem_err_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

endmodule
